// File: rtl/vec_cache_ntom_xbar_buf.sv
`default_nettype none
// ============================================================================
// Module   : vec_cache_ntom_xbar_buf
// Purpose  : N-input to M-output request crossbar with a round-robin arbiter
//            and a registered output FIFO on every bank port.
// Revision : 1.0 - initial release
// ============================================================================
module vec_cache_ntom_xbar_buf #(
  parameter int N          = 8,
  parameter int M          = 4,
  parameter int PLD_WIDTH  = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int SEL_WIDTH  = $clog2(M)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N-1:0]                        in_vld,
  input  logic [PLD_WIDTH-1:0]                in_pld    [N],
  input  logic [SEL_WIDTH-1:0]                in_select [N],
  output logic [N-1:0]                        in_rdy,
  input  logic [M-1:0]                        out_rdy,
  output logic [M-1:0]                        out_vld,
  output logic [PLD_WIDTH-1:0]                out_pld   [M],
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     out_cnt   [M],
  output logic [N-1:0]                        err_sel
);

  localparam int c_IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

  logic [N-1:0] w_req   [M];
  logic [N-1:0] w_grant [M];
  logic [N-1:0] w_bad;
  logic [N-1:0] r_err_sel;

  // Request matrix; an input matching no output is flagged as a bad select.
  always_comb begin
    for (int j = 0; j < M; j++) w_req[j] = '0;
    w_bad = '0;
    for (int i = 0; i < N; i++) begin
      w_bad[i] = in_vld[i];
      for (int j = 0; j < M; j++) begin
        if (in_vld[i] && (in_select[i] == SEL_WIDTH'(j))) begin
          w_req[j][i] = 1'b1;
          w_bad[i]    = 1'b0;
        end
      end
    end
  end

  always_comb begin
    in_rdy = '0;
    for (int j = 0; j < M; j++) in_rdy = in_rdy | w_grant[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_sel <= '0;
    else        r_err_sel <= w_bad;
  end

  assign err_sel = r_err_sel;

  for (genvar j = 0; j < M; j++) begin : g_out
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   w_win;
    logic [c_IDX_W-1:0]   w_ptr_nxt;
    logic                 w_win_vld;
    logic                 w_can_push;
    logic                 w_push;
    logic                 w_pop;
    logic [PLD_WIDTH-1:0] w_push_data;
    logic [PLD_WIDTH-1:0] w_head_nxt;
    logic [PLD_WIDTH-1:0] r_pld;
    logic [PLD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wptr;
    logic [c_AW-1:0]      r_rptr;
    logic [c_AW-1:0]      w_wptr_inc;
    logic [c_AW-1:0]      w_rptr_inc;
    logic [c_AW-1:0]      w_rptr_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_vld;

    // Rotating priority search starting at r_ptr.
    always_comb begin
      int idx;
      idx       = 0;
      w_win     = '0;
      w_win_vld = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!w_win_vld && w_req[j][c_IDX_W'(idx)]) begin
          w_win_vld = 1'b1;
          w_win     = c_IDX_W'(idx);
        end
      end
    end

    // A full FIFO still accepts when its head leaves in the same cycle.
    assign w_can_push  = (r_cnt != c_FULL) || out_rdy[j];
    assign w_push      = rst_n && w_win_vld && w_can_push;
    assign w_pop       = r_vld && out_rdy[j];
    assign w_push_data = in_pld[w_win];
    assign w_grant[j]  = w_push ? ({{(N-1){1'b0}}, 1'b1} << w_win) : '0;
    assign w_ptr_nxt   = (w_win == c_IDX_W'(N - 1)) ? '0 : w_win + 1'b1;

    assign w_wptr_inc  = (r_wptr == c_AW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_inc  = (r_rptr == c_AW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
    assign w_rptr_nxt  = w_pop ? w_rptr_inc : r_rptr;
    // The next head is the incoming entry when it lands in the head slot.
    assign w_head_nxt  = (w_push && (r_wptr == w_rptr_nxt)) ? w_push_data
                                                            : r_mem[w_rptr_nxt];

    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 1'b1;
      else if (!w_push && w_pop) w_cnt_nxt = r_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ptr  <= '0;
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
        r_vld  <= 1'b0;
        r_pld  <= '0;
      end else begin
        if (w_push) begin
          r_ptr  <= w_ptr_nxt;
          r_wptr <= w_wptr_inc;
        end
        r_rptr <= w_rptr_nxt;
        r_cnt  <= w_cnt_nxt;
        r_vld  <= (w_cnt_nxt != '0);
        // Holding r_pld when the FIFO drains keeps the last read entry visible.
        if (w_cnt_nxt != '0) r_pld <= w_head_nxt;
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_push_data;
    end

    assign out_vld[j] = r_vld;
    assign out_pld[j] = r_pld;
    assign out_cnt[j] = r_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_cache_ntom_xbar_buf.sv
`default_nettype none
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_vec_cache_ntom_xbar_buf;

  localparam int N = 8;
  localparam int M = 4;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [N-1:0] in_vld;
  logic [31:0] in_pld    [N];
  logic [1:0]  in_select [N];
  logic [N-1:0] in_rdy;
  logic [M-1:0] out_rdy;
  logic [M-1:0] out_vld;
  logic [31:0] out_pld   [M];
  logic [1:0]  out_cnt   [M];
  logic [N-1:0] err_sel;

  // Second build with three outputs so that a select value of 3 is illegal.
  logic [N-1:0] in_vld3;
  logic [31:0] in_pld3    [N];
  logic [1:0]  in_select3 [N];
  logic [N-1:0] in_rdy3;
  logic [2:0]  out_rdy3;
  logic [2:0]  out_vld3;
  logic [31:0] out_pld3   [3];
  logic [1:0]  out_cnt3   [3];
  logic [N-1:0] err_sel3;

  always #5 clk = ~clk;

  vec_cache_ntom_xbar_buf #(.N(N), .M(M), .PLD_WIDTH(32), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_pld(in_pld),
    .in_select(in_select), .in_rdy(in_rdy), .out_rdy(out_rdy),
    .out_vld(out_vld), .out_pld(out_pld), .out_cnt(out_cnt), .err_sel(err_sel)
  );

  vec_cache_ntom_xbar_buf #(.N(N), .M(3), .PLD_WIDTH(32), .FIFO_DEPTH(D)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld3), .in_pld(in_pld3),
    .in_select(in_select3), .in_rdy(in_rdy3), .out_rdy(out_rdy3),
    .out_vld(out_vld3), .out_pld(out_pld3), .out_cnt(out_cnt3), .err_sel(err_sel3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0]  mq [M][$];
  int           mptr  [M];
  logic [31:0]  mlast [M];
  int           mwin  [M];
  logic [N-1:0] exp_rdy;
  logic [N-1:0] got_rdy;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < M; j++) begin
      mq[j].delete();
      mptr[j]  = 0;
      mlast[j] = '0;
      mwin[j]  = -1;
    end
  endfunction

  // Winner per output: first requester at or after the pointer, mod N.
  function automatic void model_grant();
    exp_rdy = '0;
    for (int j = 0; j < M; j++) begin
      mwin[j] = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mptr[j] + k) % N;
        if (mwin[j] < 0 && in_vld[i] && int'(in_select[i]) == j) mwin[j] = i;
      end
      if (mwin[j] >= 0 && (mq[j].size() < D || out_rdy[j])) exp_rdy[mwin[j]] = 1'b1;
    end
  endfunction

  function automatic void model_edge();
    for (int j = 0; j < M; j++) begin
      if (mq[j].size() > 0 && out_rdy[j]) mlast[j] = mq[j].pop_front();
      if (mwin[j] >= 0 && exp_rdy[mwin[j]]) begin
        mq[j].push_back(in_pld[mwin[j]]);
        mptr[j] = (mwin[j] + 1) % N;
      end
    end
  endfunction

  function automatic void check_outputs();
    for (int j = 0; j < M; j++) begin
      chk($sformatf("out_vld[%0d]", j), 64'(out_vld[j]), 64'(mq[j].size() > 0));
      chk($sformatf("out_cnt[%0d]", j), 64'(out_cnt[j]), 64'(mq[j].size()));
      chk($sformatf("out_pld[%0d]", j), 64'(out_pld[j]),
          64'((mq[j].size() > 0) ? mq[j][0] : mlast[j]));
    end
    chk("err_sel", 64'(err_sel), 64'(0));
  endfunction

  // One clock: check in_rdy against the model, clock, then check outputs.
  task automatic cycle();
    #1;
    model_grant();
    got_rdy = in_rdy;
    chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic clear_inputs();
    in_vld  = '0;
    in_vld3 = '0;
    for (int i = 0; i < N; i++) begin
      in_pld[i] = '0; in_select[i] = '0;
      in_pld3[i] = '0; in_select3[i] = '0;
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    in_vld = '1;
    #1;
    chk("rst in_rdy", 64'(in_rdy), 64'(0));
    chk("rst out_vld", 64'(out_vld), 64'(0));
    chk("rst err_sel", 64'(err_sel), 64'(0));
    for (int j = 0; j < M; j++) begin
      chk($sformatf("rst out_cnt[%0d]", j), 64'(out_cnt[j]), 64'(0));
      chk($sformatf("rst out_pld[%0d]", j), 64'(out_pld[j]), 64'(0));
    end
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    out_rdy  = '1;
    out_rdy3 = '1;
    model_reset();
    do_reset();

    // Single path: input 3 -> output 2
    in_vld[3] = 1'b1; in_select[3] = 2'd2; in_pld[3] = 32'hA5;
    cycle();
    chk("single in_rdy", 64'(got_rdy), 64'h08);
    chk("single out_vld", 64'(out_vld), 64'h4);
    chk("single out_pld", 64'(out_pld[2]), 64'hA5);
    in_vld = '0;
    cycle();

    // Round robin among inputs 0,1,5 on output 0
    do_reset();
    for (int i = 0; i < N; i++) in_pld[i] = 32'h100 + i;
    in_vld[0] = 1'b1; in_vld[1] = 1'b1; in_vld[5] = 1'b1;
    begin
      logic [N-1:0] rr_exp [6];
      rr_exp[0] = 8'h01; rr_exp[1] = 8'h02; rr_exp[2] = 8'h20;
      rr_exp[3] = 8'h01; rr_exp[4] = 8'h02; rr_exp[5] = 8'h20;
      for (int c = 0; c < 6; c++) begin
        cycle();
        chk($sformatf("rr grant %0d", c), 64'(got_rdy), 64'(rr_exp[c]));
      end
    end
    in_vld = '0;
    cycle();

    // Backpressure on output 1
    out_rdy = 4'b1101;
    in_vld[2] = 1'b1; in_select[2] = 2'd1; in_pld[2] = 32'h10;
    cycle();
    chk("bp push0", 64'(got_rdy), 64'h04);
    in_pld[2] = 32'h11;
    cycle();
    chk("bp push1", 64'(got_rdy), 64'h04);
    in_pld[2] = 32'h12;
    cycle();
    chk("bp blocked", 64'(got_rdy), 64'h00);
    chk("bp cnt full", 64'(out_cnt[1]), 64'd2);
    chk("bp head", 64'(out_pld[1]), 64'h10);
    out_rdy = '1;
    cycle();
    chk("bp push+pop", 64'(got_rdy), 64'h04);
    chk("bp cnt hold", 64'(out_cnt[1]), 64'd2);
    chk("bp head2", 64'(out_pld[1]), 64'h11);
    in_vld = '0;
    cycle();
    chk("bp head3", 64'(out_pld[1]), 64'h12);
    cycle();
    chk("bp drained vld", 64'(out_vld[1]), 64'd0);
    chk("bp last pld", 64'(out_pld[1]), 64'h12);

    // Parallel paths: input i -> output 3-i
    for (int i = 0; i < 4; i++) begin
      in_vld[i] = 1'b1; in_select[i] = 2'(3 - i); in_pld[i] = 32'h200 + i;
    end
    cycle();
    chk("par in_rdy", 64'(got_rdy), 64'h0F);
    chk("par out_vld", 64'(out_vld), 64'hF);
    chk("par out3", 64'(out_pld[3]), 64'h200);
    chk("par out0", 64'(out_pld[0]), 64'h203);
    in_vld = '0;
    cycle();

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (in_vld[i] && exp_rdy[i]) in_vld[i] = 1'b0;
        if (!in_vld[i] && $urandom_range(0, 99) < 45) begin
          in_vld[i]    = 1'b1;
          in_select[i] = 2'($urandom_range(0, M - 1));
          in_pld[i]    = $urandom;
        end
      end
      for (int j = 0; j < M; j++) out_rdy[j] = ($urandom_range(0, 99) < 60);
      exp_rdy = '0;
      cycle();
    end

    // Reset with FIFOs partly filled
    in_vld = '0;
    out_rdy = '1;
    cycle();
    cycle();
    cycle();
    out_rdy = '0;
    for (int i = 0; i < 4; i++) begin
      in_vld[i] = 1'b1; in_select[i] = 2'(3 - i); in_pld[i] = 32'h300 + i;
    end
    cycle();
    chk("pre-rst cnt0", 64'(out_cnt[0]), 64'd1);
    do_reset();
    out_rdy = '1;

    // Illegal select on the three-output build
    in_vld3[4] = 1'b1; in_select3[4] = 2'd3; in_pld3[4] = 32'h44;
    in_vld3[1] = 1'b1; in_select3[1] = 2'd2; in_pld3[1] = 32'h77;
    #1;
    chk("err in_rdy3", 64'(in_rdy3), 64'h02);
    @(posedge clk); #1;
    chk("err pulse", 64'(err_sel3), 64'h10);
    chk("err out_vld3", 64'(out_vld3), 64'h4);
    chk("err out_pld3", 64'(out_pld3[2]), 64'h77);
    in_vld3[1] = 1'b0;
    #1;
    chk("err in_rdy3 hold", 64'(in_rdy3), 64'h00);
    @(posedge clk); #1;
    chk("err repeat", 64'(err_sel3), 64'h10);
    in_vld3[4] = 1'b0;
    @(posedge clk); #1;
    chk("err clear", 64'(err_sel3), 64'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
